// File: rtl/udp_fragment_reassembly_buffer_pkg.sv
// udp_reassembly_pkg: slot state, slot record and output-beat types shared by the reassembly buffer.
package udp_reassembly_pkg;
  localparam int SLOT_DEPTH_DEFAULT = 2048;
  localparam logic [15:0] STALE_LIMIT_DEFAULT = 16'h0FFF;
  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_COMPLETE, S_DRAINING} slot_state_t;
  typedef struct packed {
    slot_state_t state;
    logic [15:0] count;
    logic [15:0] packet_id;
    logic [15:0] idle;
  } slot_rec_t;
  typedef struct packed {
    logic [7:0] data;
    logic last;
    logic [15:0] packet_id;
  } out_beat_t;
endpackage

// File: rtl/udp_fragment_reassembly_buffer_if.sv
// udp_fragment_reassembly_buffer_if: push side from the receive handler and byte stream to the payload consumer.
interface udp_fragment_reassembly_buffer_if #(parameter int FRAGMENT_SLOTS = 2);
  logic [7:0] push_data;
  logic [FRAGMENT_SLOTS-1:0] push_data_valid;
  logic [FRAGMENT_SLOTS-1:0] push_data_last;
  logic [15:0] packet_id;
  logic out_ready;
  logic [FRAGMENT_SLOTS-1:0] fragment_slot_empty;
  logic [FRAGMENT_SLOTS-1:0][15:0] fragment_slot_packet_id;
  logic [7:0] out_data;
  logic out_valid;
  logic out_last;
  logic [15:0] out_packet_id;
  logic overflow_drop;
  logic stale_flush;
  modport master (
    output push_data, push_data_valid, push_data_last, packet_id, out_ready,
    input fragment_slot_empty, fragment_slot_packet_id, out_data, out_valid, out_last,
    out_packet_id, overflow_drop, stale_flush
  );
  modport slave (
    input push_data, push_data_valid, push_data_last, packet_id, out_ready,
    output fragment_slot_empty, fragment_slot_packet_id, out_data, out_valid, out_last,
    out_packet_id, overflow_drop, stale_flush
  );
endinterface

// File: rtl/udp_fragment_reassembly_buffer_fragment_slot_ram.sv
// fragment_slot_ram: simple dual-port byte RAM with registered read, addressed {slot, offset}.
module fragment_slot_ram #(parameter int AW = 12) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [2**AW];
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/udp_fragment_reassembly_buffer.sv
// udp_fragment_reassembly_buffer: per-slot fragment buffer draining completed slots round-robin.
// Define UDP_REASSEMBLY_STALE_TIMEOUT_EN to flush FILLING slots left idle for STALE_LIMIT cycles.
module udp_fragment_reassembly_buffer
  import udp_reassembly_pkg::*;
#(
  parameter int FRAGMENT_SLOTS = 2,
  parameter int SLOT_DEPTH = SLOT_DEPTH_DEFAULT,
  parameter logic [15:0] STALE_LIMIT = STALE_LIMIT_DEFAULT
) (
  input logic clock,
  input logic reset_n,
  udp_fragment_reassembly_buffer_if.slave bus
);
  localparam int SW = $clog2(FRAGMENT_SLOTS);
  localparam int OW = $clog2(SLOT_DEPTH);
  localparam logic [15:0] DEPTH = 16'(SLOT_DEPTH);
`ifdef UDP_REASSEMBLY_STALE_TIMEOUT_EN
  localparam bit STALE_EN = 1'b1;
`else
  localparam bit STALE_EN = 1'b0;
`endif
  slot_rec_t r_slot [FRAGMENT_SLOTS];
  slot_rec_t w_nxt [FRAGMENT_SLOTS];
  out_beat_t r_buf [2];
  out_beat_t w_head;
  logic r_wp, r_rp, r_drain_active, r_rd_pend, r_pend_last, r_ovf, r_stale;
  logic [1:0] r_fcnt, w_occ;
  logic [SW-1:0] r_drain_slot, r_rr_ptr, w_vidx, w_lidx, w_gidx, w_cand;
  logic [15:0] r_rd_ptr, r_pend_pid;
  logic w_vany, w_lany, w_grant, w_we, w_drop, w_flush, w_pop, w_done, w_issue;
  logic [SW+OW-1:0] w_waddr, w_raddr;
  logic [7:0] w_rdata;
  always_comb begin
    w_vany = 1'b0;
    w_vidx = '0;
    w_lany = 1'b0;
    w_lidx = '0;
    for (int i = FRAGMENT_SLOTS - 1; i >= 0; i--) begin
      if (bus.push_data_valid[i]) begin w_vany = 1'b1; w_vidx = SW'(i); end
      if (bus.push_data_last[i]) begin w_lany = 1'b1; w_lidx = SW'(i); end
    end
  end
  // Search from the slot after the last one drained; descending loop lets the nearest win.
  always_comb begin
    w_grant = 1'b0;
    w_gidx = '0;
    w_cand = '0;
    for (int i = FRAGMENT_SLOTS - 1; i >= 0; i--) begin
      w_cand = r_rr_ptr + SW'(i);
      if (!r_drain_active && r_slot[w_cand].state == S_COMPLETE) begin w_grant = 1'b1; w_gidx = w_cand; end
    end
  end
  assign w_head = r_buf[r_rp];
  assign w_pop = r_fcnt != 2'd0 && bus.out_ready;
  assign w_done = w_pop && w_head.last;
  assign w_occ = r_fcnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
  assign w_issue = r_drain_active && r_rd_ptr < r_slot[r_drain_slot].count && w_occ < 2'd2;
  assign w_raddr = {r_drain_slot, r_rd_ptr[OW-1:0]};
  always_comb begin
    w_nxt = r_slot;
    w_we = 1'b0;
    w_waddr = '0;
    w_drop = 1'b0;
    w_flush = 1'b0;
    for (int s = 0; s < FRAGMENT_SLOTS; s++) begin
      if (w_vany && w_vidx == SW'(s)) begin
        if (r_slot[s].state == S_EMPTY || (r_slot[s].state == S_FILLING && r_slot[s].count != DEPTH)) begin
          w_we = 1'b1;
          w_waddr = {SW'(s), r_slot[s].count[OW-1:0]};
          w_nxt[s].count = r_slot[s].count + 16'd1;
          w_nxt[s].packet_id = r_slot[s].state == S_EMPTY ? bus.packet_id : r_slot[s].packet_id;
          w_nxt[s].state = S_FILLING;
        end else w_drop = 1'b1;
        w_nxt[s].idle = '0;
      end else if (STALE_EN && r_slot[s].state == S_FILLING) begin
        w_nxt[s].idle = r_slot[s].idle + 16'd1;
        if (r_slot[s].idle == STALE_LIMIT - 16'd1 && !(w_lany && w_lidx == SW'(s))) begin
          w_nxt[s] = '0;
          w_flush = 1'b1;
        end
      end
      if (w_lany && w_lidx == SW'(s) && w_nxt[s].state == S_FILLING) w_nxt[s].state = S_COMPLETE;
    end
    if (w_grant) w_nxt[w_gidx].state = S_DRAINING;
    if (w_done) w_nxt[r_drain_slot] = '0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_slot <= '{default: '0};
    else r_slot <= w_nxt;
  end
  always_comb begin
    bus.fragment_slot_empty = '0;
    bus.fragment_slot_packet_id = '0;
    for (int s = 0; s < FRAGMENT_SLOTS; s++) begin
      bus.fragment_slot_empty[s] = r_slot[s].state == S_EMPTY;
      bus.fragment_slot_packet_id[s] = r_slot[s].packet_id;
    end
  end
  // Read one cycle ahead into a 2-entry skid so a stalled consumer never loses a byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_buf <= '{default: '0};
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_fcnt <= '0;
      r_drain_active <= 1'b0;
      r_drain_slot <= '0;
      r_rr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rd_pend <= 1'b0;
      r_pend_last <= 1'b0;
      r_pend_pid <= '0;
      r_ovf <= 1'b0;
      r_stale <= 1'b0;
    end else begin
      r_ovf <= w_drop;
      r_stale <= w_flush;
      r_rd_pend <= w_issue;
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 16'd1;
        r_pend_last <= r_rd_ptr == r_slot[r_drain_slot].count - 16'd1;
        r_pend_pid <= r_slot[r_drain_slot].packet_id;
      end
      if (w_grant) begin
        r_drain_active <= 1'b1;
        r_drain_slot <= w_gidx;
        r_rd_ptr <= '0;
      end
      if (w_done) begin
        r_drain_active <= 1'b0;
        r_rr_ptr <= r_drain_slot + SW'(1);
      end
      if (r_rd_pend) begin
        r_buf[r_wp] <= '{data: w_rdata, last: r_pend_last, packet_id: r_pend_pid};
        r_wp <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_fcnt <= w_occ;
    end
  end
  assign bus.out_valid = r_fcnt != 2'd0;
  assign bus.out_data = w_head.data;
  assign bus.out_last = w_head.last;
  assign bus.out_packet_id = w_head.packet_id;
  assign bus.overflow_drop = r_ovf;
  assign bus.stale_flush = r_stale;
  fragment_slot_ram #(.AW(SW + OW)) u_ram (
    .clock  (clock),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(bus.push_data),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );
endmodule
